// File: rtl/depar_seg_splitter_pkg.sv
// Shared deparser definitions.
//   state_t : segment splitter FSM encoding (IDLE/HDR/PAD/PAY)
//   clog2   : ceiling log2, used to size the header segment index
package depar_seg_splitter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_HDR  = 2'd1,
        ST_PAD  = 2'd2,
        ST_PAY  = 2'd3
    } state_t;

    function automatic int clog2(input int value);
        int r;
        r = 0;
        for (int v = value - 1; v > 0; v = v >> 1) begin
            r = r + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/depar_seg_splitter.sv
// Deparser front end: pops beats from a fall-through packet FIFO, steers the
// first NUM_HDR_SEGS beats to per-segment header channels, captures the VLAN
// ID from beat 0 and forwards the remaining beats to the payload channel.
// Packets shorter than NUM_HDR_SEGS beats are padded with zero-filled filler
// entries (tkeep=0, tlast=1) so every header channel gets one entry/packet.
//
// Ports:
//   axis_clk, reset            clock, asynchronous active-high reset
//   pkt_fifo_*                 head of packet FIFO in, pkt_fifo_rd_en pop out
//   hdr_*                      flattened header channels (channel k = slice k)
//   vlan, vlan_valid/ready     VLAN ID channel
//   pay_*                      payload channel (tuser dropped)
//   stat_pkt_cnt/short_cnt     packets started / packets padded
module depar_seg_splitter
    import depar_seg_splitter_pkg::*;
#(
    parameter int C_AXIS_DATA_WIDTH  = 512,
    parameter int C_AXIS_TUSER_WIDTH = 128,
    parameter int NUM_HDR_SEGS       = 2,
    parameter int C_VLANID_WIDTH     = 12,
    parameter int VLAN_BIT_OFFSET    = 116
) (
    input  logic                                         axis_clk,
    input  logic                                         reset,
    input  logic [C_AXIS_DATA_WIDTH-1:0]                 pkt_fifo_tdata,
    input  logic [C_AXIS_TUSER_WIDTH-1:0]                pkt_fifo_tuser,
    input  logic [C_AXIS_DATA_WIDTH/8-1:0]               pkt_fifo_tkeep,
    input  logic                                         pkt_fifo_tlast,
    input  logic                                         pkt_fifo_empty,
    output logic                                         pkt_fifo_rd_en,
    output logic [NUM_HDR_SEGS*C_AXIS_DATA_WIDTH-1:0]    hdr_tdata,
    output logic [NUM_HDR_SEGS*C_AXIS_TUSER_WIDTH-1:0]   hdr_tuser,
    output logic [NUM_HDR_SEGS*(C_AXIS_DATA_WIDTH/8)-1:0] hdr_tkeep,
    output logic [NUM_HDR_SEGS-1:0]                      hdr_tlast,
    output logic [NUM_HDR_SEGS-1:0]                      hdr_valid,
    input  logic [NUM_HDR_SEGS-1:0]                      hdr_ready,
    output logic [C_VLANID_WIDTH-1:0]                    vlan,
    output logic                                         vlan_valid,
    input  logic                                         vlan_ready,
    output logic [C_AXIS_DATA_WIDTH-1:0]                 pay_tdata,
    output logic [C_AXIS_DATA_WIDTH/8-1:0]               pay_tkeep,
    output logic                                         pay_tlast,
    output logic                                         pay_valid,
    input  logic                                         pay_ready,
    output logic [31:0]                                  stat_pkt_cnt,
    output logic [31:0]                                  stat_short_cnt
);

    localparam int DW    = C_AXIS_DATA_WIDTH;
    localparam int TW    = C_AXIS_TUSER_WIDTH;
    localparam int KW    = C_AXIS_DATA_WIDTH / 8;
    localparam int SEG_W = (clog2(NUM_HDR_SEGS) > 0) ? clog2(NUM_HDR_SEGS) : 1;
    localparam logic [SEG_W-1:0] LAST_SEG = SEG_W'(NUM_HDR_SEGS - 1);

    state_t                 state, state_nxt;
    logic [SEG_W-1:0]       seg_idx, seg_nxt;
    logic                   rd_en;
    logic                   pad_fire;
    logic [NUM_HDR_SEGS-1:0] ch_load, ch_pad;

    logic [NUM_HDR_SEGS-1:0][DW-1:0] hdr_data_q;
    logic [NUM_HDR_SEGS-1:0][TW-1:0] hdr_user_q;
    logic [NUM_HDR_SEGS-1:0][KW-1:0] hdr_keep_q;

    always_comb begin
        state_nxt = state;
        seg_nxt   = seg_idx;
        rd_en     = 1'b0;
        pad_fire  = 1'b0;
        case (state)
            ST_IDLE: begin
                rd_en = ~pkt_fifo_empty & hdr_ready[0] & vlan_ready;
                if (rd_en) begin
                    seg_nxt = SEG_W'(1);
                    if (pkt_fifo_tlast)
                        state_nxt = (NUM_HDR_SEGS > 1) ? ST_PAD : ST_IDLE;
                    else
                        state_nxt = (NUM_HDR_SEGS > 1) ? ST_HDR : ST_PAY;
                end
            end
            ST_HDR: begin
                rd_en = ~pkt_fifo_empty & hdr_ready[seg_idx];
                if (rd_en) begin
                    seg_nxt = seg_idx + SEG_W'(1);
                    if (pkt_fifo_tlast)
                        state_nxt = (seg_idx < LAST_SEG) ? ST_PAD : ST_IDLE;
                    else if (seg_idx == LAST_SEG)
                        state_nxt = ST_PAY;
                end
            end
            ST_PAD: begin
                // No pop here: filler entries are generated locally.
                if (hdr_ready[seg_idx]) begin
                    pad_fire = 1'b1;
                    if (seg_idx == LAST_SEG) begin
                        state_nxt = ST_IDLE;
                        seg_nxt   = '0;
                    end else begin
                        seg_nxt = seg_idx + SEG_W'(1);
                    end
                end
            end
            ST_PAY: begin
                rd_en = ~pkt_fifo_empty & pay_ready;
                if (rd_en && pkt_fifo_tlast)
                    state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // IDLE is the reset state and would otherwise pop while reset is held.
    assign pkt_fifo_rd_en = rd_en & ~reset;

    genvar k;
    generate
        for (k = 0; k < NUM_HDR_SEGS; k++) begin : g_ch
            assign ch_load[k] = rd_en & (((k == 0) && (state == ST_IDLE)) ||
                                         ((state == ST_HDR) && (seg_idx == SEG_W'(k))));
            assign ch_pad[k]  = pad_fire & (seg_idx == SEG_W'(k));
            assign hdr_tdata[k*DW +: DW] = hdr_data_q[k];
            assign hdr_tuser[k*TW +: TW] = hdr_user_q[k];
            assign hdr_tkeep[k*KW +: KW] = hdr_keep_q[k];
        end
    endgenerate

    always_ff @(posedge axis_clk or posedge reset) begin
        if (reset) begin
            state          <= ST_IDLE;
            seg_idx        <= '0;
            hdr_data_q     <= '0;
            hdr_user_q     <= '0;
            hdr_keep_q     <= '0;
            hdr_tlast      <= '0;
            hdr_valid      <= '0;
            vlan           <= '0;
            vlan_valid     <= 1'b0;
            pay_tdata      <= '0;
            pay_tkeep      <= '0;
            pay_tlast      <= 1'b0;
            pay_valid      <= 1'b0;
            stat_pkt_cnt   <= '0;
            stat_short_cnt <= '0;
        end else begin
            state   <= state_nxt;
            seg_idx <= seg_nxt;

            for (int c = 0; c < NUM_HDR_SEGS; c++) begin
                hdr_valid[c] <= ch_load[c] | ch_pad[c];
                if (ch_load[c]) begin
                    hdr_data_q[c] <= pkt_fifo_tdata;
                    hdr_user_q[c] <= pkt_fifo_tuser;
                    hdr_keep_q[c] <= pkt_fifo_tkeep;
                    hdr_tlast[c]  <= pkt_fifo_tlast;
                end else if (ch_pad[c]) begin
                    hdr_data_q[c] <= '0;
                    hdr_user_q[c] <= '0;
                    hdr_keep_q[c] <= '0;
                    hdr_tlast[c]  <= 1'b1;
                end
            end

            vlan_valid <= rd_en & (state == ST_IDLE);
            if (rd_en && state == ST_IDLE) begin
                vlan         <= pkt_fifo_tdata[VLAN_BIT_OFFSET +: C_VLANID_WIDTH];
                stat_pkt_cnt <= stat_pkt_cnt + 32'd1;
            end

            pay_valid <= rd_en & (state == ST_PAY);
            if (rd_en && state == ST_PAY) begin
                pay_tdata <= pkt_fifo_tdata;
                pay_tkeep <= pkt_fifo_tkeep;
                pay_tlast <= pkt_fifo_tlast;
            end

            if (state != ST_PAD && state_nxt == ST_PAD)
                stat_short_cnt <= stat_short_cnt + 32'd1;
        end
    end

endmodule
